// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, imem req/valid handshake, IF/ID register with 1-entry skid, HLT stop
// Optional FETCH_PERF_CNT_EN adds saturating fetch_count/stall_count outputs.
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_data,
  output logic        if_id_valid,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc_plus2,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count,
`endif
  output logic        halted
);

  typedef enum logic [1:0] {S_REQ = 2'd0, S_HOLD = 2'd1, S_HALT = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic        kill_q, kill_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [15:0] if_id_instr_q, if_id_instr_d;
  logic [15:0] if_id_pc2_q, if_id_pc2_d;
  logic        skid_valid_q, skid_valid_d;
  logic [15:0] skid_instr_q, skid_instr_d;
  logic [15:0] skid_pc2_q, skid_pc2_d;

  logic        accept;
  logic        is_hlt;
  logic [15:0] fetch_pc2;

  // A word is only consumed when it answers a live (non-killed) request and no redirect overrides it.
  assign accept    = req_q && imem_valid && !kill_q && !redirect_valid;
  assign is_hlt    = (imem_data[15:12] == HLT_OPCODE);
  assign fetch_pc2 = addr_q + 16'd2;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    kill_d        = kill_q;
    if_id_valid_d = if_id_valid_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc2_d   = if_id_pc2_q;
    skid_valid_d  = skid_valid_q;
    skid_instr_d  = skid_instr_q;
    skid_pc2_d    = skid_pc2_q;

    if (redirect_valid) begin
      state_d       = S_REQ;
      pc_d          = redirect_pc & 16'hFFFE;
      kill_d        = req_q && !imem_valid;
      if_id_valid_d = 1'b0;
      skid_valid_d  = 1'b0;
    end else begin
      if (kill_q && imem_valid) begin
        kill_d = 1'b0;
      end
      if (!stall) begin
        if (skid_valid_q) begin
          if_id_valid_d = 1'b1;
          if_id_instr_d = skid_instr_q;
          if_id_pc2_d   = skid_pc2_q;
          skid_valid_d  = 1'b0;
          if (state_q == S_HOLD) begin
            state_d = S_REQ;
          end
        end else if (accept) begin
          if_id_valid_d = 1'b1;
          if_id_instr_d = imem_data;
          if_id_pc2_d   = fetch_pc2;
        end else begin
          if_id_valid_d = 1'b0;
        end
      end else if (accept) begin
        skid_valid_d = 1'b1;
        skid_instr_d = imem_data;
        skid_pc2_d   = fetch_pc2;
      end
      if (accept) begin
        pc_d = pc_q + 16'd2;
        if (is_hlt) begin
          state_d = S_HALT;
        end else if (stall) begin
          state_d = S_HOLD;
        end
      end
    end

    // While a killed request is in flight the old address must stay on the bus.
    req_d  = (state_d == S_REQ);
    addr_d = kill_d ? addr_q : pc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      addr_q        <= RESET_PC;
      req_q         <= 1'b0;
      kill_q        <= 1'b0;
      if_id_valid_q <= 1'b0;
      if_id_instr_q <= 16'h0000;
      if_id_pc2_q   <= 16'h0000;
      skid_valid_q  <= 1'b0;
      skid_instr_q  <= 16'h0000;
      skid_pc2_q    <= 16'h0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      addr_q        <= addr_d;
      req_q         <= req_d;
      kill_q        <= kill_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc2_q   <= if_id_pc2_d;
      skid_valid_q  <= skid_valid_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc2_q    <= skid_pc2_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (accept && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (stall && if_id_valid_q && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

  assign imem_req       = req_q;
  assign imem_addr      = addr_q;
  assign if_id_valid    = if_id_valid_q;
  assign if_id_instr    = if_id_instr_q;
  assign if_id_pc_plus2 = if_id_pc2_q;
  assign halted         = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - vector table, corner sequences and randomized scoreboard for fetch_stage
module tb_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_req, imem_valid;
  logic [15:0] imem_addr, imem_data;
  logic        if_id_valid, halted;
  logic [15:0] if_id_instr, if_id_pc_plus2;

  logic        rst2_n, req2, v2, halted2;
  logic [15:0] addr2, instr2, pc2_2;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, stall_count, fetch_count2, stall_count2;
`endif

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data), .if_id_valid(if_id_valid),
    .if_id_instr(if_id_instr), .if_id_pc_plus2(if_id_pc_plus2),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count(fetch_count), .stall_count(stall_count),
`endif
    .halted(halted)
  );

  fetch_stage #(.RESET_PC(16'hFFFC)) dut2 (
    .clk(clk), .rst_n(rst2_n), .stall(1'b0), .redirect_valid(1'b0),
    .redirect_pc(16'h0000), .imem_req(req2), .imem_addr(addr2),
    .imem_valid(req2), .imem_data(addr2 ^ 16'h5A5A), .if_id_valid(v2),
    .if_id_instr(instr2), .if_id_pc_plus2(pc2_2),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count(fetch_count2), .stall_count(stall_count2),
`endif
    .halted(halted2)
  );

  // Instruction memory: answers after 'lat' waiting cycles (0 = same cycle as the request).
  logic [15:0] mem [0:32767];
  logic [3:0]  wait_cnt, lat_fixed, lat_rand, lat;
  logic        rand_lat;
  assign lat        = rand_lat ? lat_rand : lat_fixed;
  assign imem_valid = imem_req && (wait_cnt >= lat);
  assign imem_data  = mem[imem_addr[15:1]];

  always @(posedge clk) begin
    if (!imem_req || imem_valid) begin
      wait_cnt <= 4'd0;
      lat_rand <= 4'($urandom_range(0, 2));
    end else begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        stall;
    logic        req;
    logic [15:0] addr;
    logic        v;
    logic [15:0] instr;
    logic [15:0] pc2;
  } vec_t;

  vec_t        vecs [7];
  logic [15:0] tmp, exp_pc, rpc, p_addr, p_instr, p_pc2;
  logic        p_req, p_valid, p_v, seen;
  int          delivered;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[1] = '{1'b0, 1'b1, 16'h0002, 1'b1, 16'hB123, 16'h0002};
    vecs[2] = '{1'b0, 1'b1, 16'h0004, 1'b1, 16'h1234, 16'h0004};
    vecs[3] = '{1'b1, 1'b0, 16'h0006, 1'b1, 16'h1234, 16'h0004};
    vecs[4] = '{1'b1, 1'b0, 16'h0006, 1'b1, 16'h1234, 16'h0004};
    vecs[5] = '{1'b1, 1'b0, 16'h0006, 1'b1, 16'h1234, 16'h0004};
    vecs[6] = '{1'b0, 1'b1, 16'h0006, 1'b1, 16'h2222, 16'h0006};

    for (int i = 0; i < 32768; i++) begin
      tmp = 16'($urandom);
      if (tmp[15:12] == 4'hF) tmp[15:12] = 4'h7;
      mem[i] = tmp;
    end
    mem[0] = 16'hB123;
    mem[1] = 16'h1234;
    mem[2] = 16'h2222;
    mem[3] = 16'h3333;
    mem[8] = 16'hF000;

    rst_n = 1'b0; rst2_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
    lat_fixed = 4'd0; rand_lat = 1'b0;
    tick();
    tick();

    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_if_valid", if_id_valid, 0);
    chk("rst_instr", if_id_instr, 16'h0000);
    chk("rst_pc2", if_id_pc_plus2, 16'h0000);
    chk("rst_halted", halted, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_fetch_count", fetch_count, 0);
    chk("rst_stall_count", stall_count, 0);
`endif

    // RESET_PC=FFFC: sequential wrap, then asynchronous reset mid-request.
    rst2_n = 1'b1;
    tick();
    chk("t5_req_first", req2, 1);
    chk("t5_addr_fffc", addr2, 16'hFFFC);
    tick();
    chk("t5_addr_fffe", addr2, 16'hFFFE);
    chk("t5_instr0", instr2, 16'hA5A6);
    chk("t5_pc2_0", pc2_2, 16'hFFFE);
    tick();
    chk("t5_addr_wrap", addr2, 16'h0000);
    chk("t5_instr1", instr2, 16'hA5A4);
    chk("t5_pc2_wrap", pc2_2, 16'h0000);
    #3;
    rst2_n = 1'b0;
    #1;
    chk("t5_async_req", req2, 0);
    chk("t5_async_valid", v2, 0);
    chk("t5_async_addr", addr2, 16'hFFFC);
    tick();
    rst2_n = 1'b1;
    tick();
    chk("t5_restart_req", req2, 1);
    chk("t5_restart_addr", addr2, 16'hFFFC);

    // Zero-wait sequential fetch, then a 3-cycle stall absorbing the 0004 response in the skid.
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      stall = vecs[i].stall;
      tick();
      chk($sformatf("vec%0d_req", i), imem_req, vecs[i].req);
      chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].addr);
      chk($sformatf("vec%0d_valid", i), if_id_valid, vecs[i].v);
      chk($sformatf("vec%0d_instr", i), if_id_instr, vecs[i].instr);
      chk($sformatf("vec%0d_pc2", i), if_id_pc_plus2, vecs[i].pc2);
      chk($sformatf("vec%0d_halted", i), halted, 0);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("t6_fetch_count", fetch_count, 3);
    chk("t6_stall_count", stall_count, 3);
`endif

    // 3-cycle memory; redirect lands while the 0006 request is outstanding.
    lat_fixed = 4'd3;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0041;
    tick();
    redirect_valid = 1'b0;
    chk("t3_bubble", if_id_valid, 0);
    chk("t3_addr_hold", imem_addr, 16'h0006);
    chk("t3_req_hold", imem_req, 1);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (imem_addr != 16'h0006) seen = 1'b1;
      else begin
        chk("t3_wait_req", imem_req, 1);
        chk("t3_wait_bubble", if_id_valid, 0);
      end
    end
    chk("t3_addr_moved", seen, 1);
    chk("t3_target_addr", imem_addr, 16'h0040);
    chk("t3_killed_dropped", if_id_valid, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("t6_killed_not_counted", fetch_count, 3);
`endif
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (if_id_valid) seen = 1'b1;
    end
    chk("t3_target_delivered", seen, 1);
    chk("t3_target_instr", if_id_instr, mem[16'h0020]);
    chk("t3_target_pc2", if_id_pc_plus2, 16'h0042);
`ifdef FETCH_PERF_CNT_EN
    chk("t6_target_counted", fetch_count, 4);
`endif

    // HLT at 0010, hold for 20 cycles, then redirect out of HALT.
    lat_fixed = 4'd0;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0010;
    tick();
    redirect_valid = 1'b0;
    chk("t4_addr", imem_addr, 16'h0010);
    chk("t4_not_halted", halted, 0);
    tick();
    chk("t4_halted", halted, 1);
    chk("t4_hlt_instr", if_id_instr, 16'hF000);
    chk("t4_hlt_valid", if_id_valid, 1);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("t4_halt_req", imem_req, 0);
      chk("t4_halt_pc", imem_addr, 16'h0012);
      chk("t4_halt_flag", halted, 1);
    end
    redirect_valid = 1'b1;
    redirect_pc = 16'h0020;
    tick();
    redirect_valid = 1'b0;
    chk("t4_resume_halted", halted, 0);
    chk("t4_resume_req", imem_req, 1);
    chk("t4_resume_addr", imem_addr, 16'h0020);
    tick();
    chk("t4_resume_instr", if_id_instr, mem[16'h0010]);
    chk("t4_resume_pc2", if_id_pc_plus2, 16'h0022);

    // Random stalls, redirects and memory latency against an in-order program-stream scoreboard.
    rand_lat = 1'b1;
    exp_pc = 16'h0022;
    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      stall = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      rpc = 16'h0100 | 16'($urandom_range(0, 255));
      redirect_pc = rpc;
      p_req = imem_req; p_valid = imem_valid; p_addr = imem_addr;
      p_v = if_id_valid; p_instr = if_id_instr; p_pc2 = if_id_pc_plus2;
      tick();
      if (p_req && !p_valid) begin
        chk("rand_req_held", imem_req, 1);
        chk("rand_addr_held", imem_addr, p_addr);
      end
      if (redirect_valid) begin
        chk("rand_redirect_bubble", if_id_valid, 0);
        exp_pc = rpc & 16'hFFFE;
      end else if (stall) begin
        chk("rand_stall_valid", if_id_valid, p_v);
        chk("rand_stall_instr", if_id_instr, p_instr);
        chk("rand_stall_pc2", if_id_pc_plus2, p_pc2);
      end else if (if_id_valid) begin
        chk("rand_instr", if_id_instr, mem[exp_pc[15:1]]);
        chk("rand_pc2", if_id_pc_plus2, exp_pc + 16'd2);
        exp_pc = exp_pc + 16'd2;
        delivered++;
      end
    end
    stall = 1'b0;
    redirect_valid = 1'b0;
    chk("rand_throughput", delivered > 300, 1);
    chk("rand_not_halted", halted, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
